// File: rtl/reorder_buffer_pkg.sv
// Shared widths, instruction class codes and the per-entry record of the reorder buffer.
package reorder_buffer_pkg;
   localparam int XLEN             = 32;
   localparam int REG_CNT_WIDTH    = 5;
   localparam int ROB_SIZE_WIDTH   = 3;
   localparam int ROB_SIZE         = 1 << ROB_SIZE_WIDTH;
   localparam int INST_TYPE_WIDTH  = 6;
   localparam int DEPENDENCY_WIDTH = ROB_SIZE_WIDTH + 1;
   localparam int CNT_WIDTH        = ROB_SIZE_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] ROB_FULL_COUNT = CNT_WIDTH'(ROB_SIZE);

   typedef enum logic [INST_TYPE_WIDTH-1:0] {
      INST_NOP  = 6'd0,
      INST_HALT,
      INST_LUI,
      INST_AUIPC,
      INST_JAL,
      INST_JALR,
      INST_BEQ,
      INST_BNE,
      INST_BLT,
      INST_BGE,
      INST_BLTU,
      INST_BGEU,
      INST_LB,
      INST_LH,
      INST_LW,
      INST_LBU,
      INST_LHU,
      INST_SB,
      INST_SH,
      INST_SW,
      INST_ADDI,
      INST_SLTI,
      INST_ANDI,
      INST_ORI,
      INST_XORI,
      INST_ADD,
      INST_SUB,
      INST_AND,
      INST_OR,
      INST_XOR
   } inst_type_e;

   typedef struct packed {
      logic                       busy;
      logic                       done;
      logic [INST_TYPE_WIDTH-1:0] itype;
      logic [REG_CNT_WIDTH-1:0]   rd;
      logic [XLEN-1:0]            pc;
      logic                       pred_taken;
      logic [XLEN-1:0]            value;
      logic                       taken;
   } rob_entry_t;

   function automatic logic is_branch(input logic [INST_TYPE_WIDTH-1:0] t);
      return (t == INST_BEQ) || (t == INST_BNE) || (t == INST_BLT) ||
             (t == INST_BGE) || (t == INST_BLTU) || (t == INST_BGEU);
   endfunction

   function automatic logic is_store(input logic [INST_TYPE_WIDTH-1:0] t);
      return (t == INST_SB) || (t == INST_SH) || (t == INST_SW);
   endfunction
endpackage

// File: rtl/reorder_buffer_rob_query_port.sv
// Forwarding lookup of one ROB tag; a same-cycle writeback to that tag is bypassed.
module rob_query_port
   import reorder_buffer_pkg::*;
(
   input  logic [ROB_SIZE_WIDTH-1:0]          qry_id,
   input  logic [ROB_SIZE-1:0]                busy,
   input  logic [ROB_SIZE-1:0]                done,
   input  logic [ROB_SIZE-1:0][XLEN-1:0]      value,
   input  logic                               alu_wb,
   input  logic [ROB_SIZE_WIDTH-1:0]          alu_id,
   input  logic [XLEN-1:0]                    alu_val,
   input  logic                               lsb_wb,
   input  logic [ROB_SIZE_WIDTH-1:0]          lsb_id,
   input  logic [XLEN-1:0]                    lsb_val,
   output logic                               qry_rdy,
   output logic [XLEN-1:0]                    qry_val
);

   always_comb begin
      qry_rdy = 1'b0;
      qry_val = value[qry_id];
      if (busy[qry_id]) begin
         if (alu_wb && (alu_id == qry_id)) begin
            qry_rdy = 1'b1;
            qry_val = alu_val;
         end else if (lsb_wb && (lsb_id == qry_id)) begin
            qry_rdy = 1'b1;
            qry_val = lsb_val;
         end else if (done[qry_id]) begin
            qry_rdy = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates at tail, captures ALU/LSB results, commits the head
// entry and raises a one-cycle flush when a committed branch was mispredicted.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       dec_ready,
   input  logic [INST_TYPE_WIDTH-1:0] dec_inst_type,
   input  logic [REG_CNT_WIDTH-1:0]   dec_rd,
   input  logic [XLEN-1:0]            dec_pc,
   input  logic                       dec_pred_taken,
   input  logic                       alu_ready,
   input  logic [ROB_SIZE_WIDTH-1:0]  alu_id,
   input  logic [XLEN-1:0]            alu_val,
   input  logic                       alu_taken,
   input  logic                       lsb_ready,
   input  logic [ROB_SIZE_WIDTH-1:0]  lsb_id,
   input  logic [XLEN-1:0]            lsb_val,
   input  logic [ROB_SIZE_WIDTH-1:0]  qry_id1,
   input  logic [ROB_SIZE_WIDTH-1:0]  qry_id2,
   output logic                       qry_rdy1,
   output logic [XLEN-1:0]            qry_val1,
   output logic                       qry_rdy2,
   output logic [XLEN-1:0]            qry_val2,
   output logic                       rob_full,
   output logic                       rob_ready,
   output logic [REG_CNT_WIDTH-1:0]   rob_rd,
   output logic [XLEN-1:0]            rob_val,
   output logic [ROB_SIZE_WIDTH-1:0]  rob_head_id,
   output logic [ROB_SIZE_WIDTH-1:0]  rob_tail_id,
   output logic                       flush,
   output logic [XLEN-1:0]            flush_pc,
   output logic                       halt
);

   rob_entry_t                 entry_q [ROB_SIZE];
   rob_entry_t                 entry_d [ROB_SIZE];
   logic [ROB_SIZE_WIDTH-1:0]  head_q, head_d;
   logic [ROB_SIZE_WIDTH-1:0]  tail_q, tail_d;
   logic [CNT_WIDTH-1:0]       count_q, count_d;
   logic                       rob_ready_q, rob_ready_d;
   logic [REG_CNT_WIDTH-1:0]   rob_rd_q, rob_rd_d;
   logic [XLEN-1:0]            rob_val_q, rob_val_d;
   logic                       flush_q, flush_d;
   logic [XLEN-1:0]            flush_pc_q, flush_pc_d;
   logic                       halt_q, halt_d;

   logic                       alu_wb, lsb_wb;
   logic                       alloc_en, commit_en;
   rob_entry_t                 head_e, new_e;
   logic [ROB_SIZE-1:0]        busy_vec, done_vec;
   logic [ROB_SIZE-1:0][XLEN-1:0] value_vec;

   assign rob_full    = (count_q == ROB_FULL_COUNT);
   assign rob_ready   = rob_ready_q;
   assign rob_rd      = rob_rd_q;
   assign rob_val     = rob_val_q;
   assign rob_head_id = head_q;
   assign rob_tail_id = tail_q;
   assign flush       = flush_q;
   assign flush_pc    = flush_pc_q;
   assign halt        = halt_q;

   // Writebacks are dropped while the flush pulse clears the queue.
   assign alu_wb = alu_ready && !flush_q;
   assign lsb_wb = lsb_ready && !flush_q;

   always_comb begin
      for (int i = 0; i < ROB_SIZE; i++) begin
         busy_vec[i]  = entry_q[i].busy;
         done_vec[i]  = entry_q[i].done;
         value_vec[i] = entry_q[i].value;
      end
   end

   always_comb begin
      new_e            = '0;
      new_e.busy       = 1'b1;
      new_e.done       = (dec_inst_type == INST_HALT);
      new_e.itype      = dec_inst_type;
      new_e.rd         = (is_store(dec_inst_type) || is_branch(dec_inst_type)) ? '0 : dec_rd;
      new_e.pc         = dec_pc;
      new_e.pred_taken = dec_pred_taken;
   end

   always_comb begin
      entry_d     = entry_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      rob_ready_d = 1'b0;
      rob_rd_d    = rob_rd_q;
      rob_val_d   = rob_val_q;
      flush_d     = 1'b0;
      flush_pc_d  = flush_pc_q;
      halt_d      = halt_q;
      alloc_en    = 1'b0;
      commit_en   = 1'b0;
      head_e      = entry_q[head_q];

      if (flush_q) begin
         // Tags restart from the retained head so younger allocations reuse the squashed slots.
         for (int i = 0; i < ROB_SIZE; i++) entry_d[i] = '0;
         tail_d  = head_q;
         count_d = '0;
      end else begin
         if (alu_wb && entry_q[alu_id].busy) begin
            entry_d[alu_id].done  = 1'b1;
            entry_d[alu_id].value = alu_val;
            entry_d[alu_id].taken = alu_taken;
         end
         if (lsb_wb && entry_q[lsb_id].busy) begin
            entry_d[lsb_id].done  = 1'b1;
            entry_d[lsb_id].value = lsb_val;
         end

         commit_en = head_e.busy && head_e.done && !halt_q;
         if (commit_en) begin
            rob_ready_d           = 1'b1;
            rob_rd_d              = head_e.rd;
            rob_val_d             = head_e.value;
            entry_d[head_q].busy  = 1'b0;
            entry_d[head_q].done  = 1'b0;
            head_d                = head_q + ROB_SIZE_WIDTH'(1);
            if (is_branch(head_e.itype) && (head_e.taken != head_e.pred_taken)) begin
               flush_d    = 1'b1;
               flush_pc_d = head_e.taken ? head_e.value : head_e.pc + XLEN'(4);
            end
            if (head_e.itype == INST_HALT) halt_d = 1'b1;
         end

         // Tail only equals a busy head when full, so allocation never collides with commit.
         alloc_en = dec_ready && !stall && !rob_full && !halt_q;
         if (alloc_en) begin
            entry_d[tail_q] = new_e;
            tail_d          = tail_q + ROB_SIZE_WIDTH'(1);
         end

         count_d = count_q + CNT_WIDTH'(alloc_en) - CNT_WIDTH'(commit_en);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ROB_SIZE; i++) entry_q[i] <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         rob_ready_q <= 1'b0;
         rob_rd_q    <= '0;
         rob_val_q   <= '0;
         flush_q     <= 1'b0;
         flush_pc_q  <= '0;
         halt_q      <= 1'b0;
      end else begin
         entry_q     <= entry_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         rob_ready_q <= rob_ready_d;
         rob_rd_q    <= rob_rd_d;
         rob_val_q   <= rob_val_d;
         flush_q     <= flush_d;
         flush_pc_q  <= flush_pc_d;
         halt_q      <= halt_d;
      end
   end

   rob_query_port u_qry1 (
      .qry_id  (qry_id1),
      .busy    (busy_vec),
      .done    (done_vec),
      .value   (value_vec),
      .alu_wb  (alu_wb),
      .alu_id  (alu_id),
      .alu_val (alu_val),
      .lsb_wb  (lsb_wb),
      .lsb_id  (lsb_id),
      .lsb_val (lsb_val),
      .qry_rdy (qry_rdy1),
      .qry_val (qry_val1)
   );

   rob_query_port u_qry2 (
      .qry_id  (qry_id2),
      .busy    (busy_vec),
      .done    (done_vec),
      .value   (value_vec),
      .alu_wb  (alu_wb),
      .alu_id  (alu_id),
      .alu_val (alu_val),
      .lsb_wb  (lsb_wb),
      .lsb_id  (lsb_id),
      .lsb_val (lsb_val),
      .qry_rdy (qry_rdy2),
      .qry_val (qry_val2)
   );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: commit scoreboard plus a vector table and
// directed sequences for reset, wrap, bypass, misprediction and HALT.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   localparam int W = REG_CNT_WIDTH + XLEN;

   logic                       clk, rst, stall;
   logic                       dec_ready, dec_pred_taken;
   logic [INST_TYPE_WIDTH-1:0] dec_inst_type;
   logic [REG_CNT_WIDTH-1:0]   dec_rd;
   logic [XLEN-1:0]            dec_pc;
   logic                       alu_ready, alu_taken, lsb_ready;
   logic [ROB_SIZE_WIDTH-1:0]  alu_id, lsb_id, qry_id1, qry_id2;
   logic [XLEN-1:0]            alu_val, lsb_val;
   logic                       qry_rdy1, qry_rdy2;
   logic [XLEN-1:0]            qry_val1, qry_val2;
   logic                       rob_full, rob_ready, flush, halt;
   logic [REG_CNT_WIDTH-1:0]   rob_rd;
   logic [XLEN-1:0]            rob_val, flush_pc;
   logic [ROB_SIZE_WIDTH-1:0]  rob_head_id, rob_tail_id;

   int n_vec = 0;
   int n_err = 0;
   int flush_cnt = 0;
   logic [ROB_SIZE_WIDTH-1:0] exp_head;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;

   typedef struct {
      inst_type_e               itype;
      logic [REG_CNT_WIDTH-1:0] rd;
      logic [XLEN-1:0]          val;
      logic                     pred;
      logic                     taken;
      logic                     use_lsb;
      logic [REG_CNT_WIDTH-1:0] exp_rd;
   } vec_t;
   vec_t vecs[8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk(clk), .rst(rst), .stall(stall),
      .dec_ready(dec_ready), .dec_inst_type(dec_inst_type), .dec_rd(dec_rd),
      .dec_pc(dec_pc), .dec_pred_taken(dec_pred_taken),
      .alu_ready(alu_ready), .alu_id(alu_id), .alu_val(alu_val), .alu_taken(alu_taken),
      .lsb_ready(lsb_ready), .lsb_id(lsb_id), .lsb_val(lsb_val),
      .qry_id1(qry_id1), .qry_id2(qry_id2),
      .qry_rdy1(qry_rdy1), .qry_val1(qry_val1), .qry_rdy2(qry_rdy2), .qry_val2(qry_val2),
      .rob_full(rob_full), .rob_ready(rob_ready), .rob_rd(rob_rd), .rob_val(rob_val),
      .rob_head_id(rob_head_id), .rob_tail_id(rob_tail_id),
      .flush(flush), .flush_pc(flush_pc), .halt(halt)
   );

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_head = '0;
   endtask

   task automatic alloc(input inst_type_e t, input logic [REG_CNT_WIDTH-1:0] rd,
                        input logic [XLEN-1:0] pc, input logic pred, input logic push,
                        input logic [REG_CNT_WIDTH-1:0] exp_rd, input logic [XLEN-1:0] exp_val);
      dec_inst_type  = t;
      dec_rd         = rd;
      dec_pc         = pc;
      dec_pred_taken = pred;
      dec_ready      = 1'b1;
      if (push) exp_q.push_back({exp_rd, exp_val});
      tick();
      dec_ready = 1'b0;
   endtask

   task automatic wb_alu(input logic [ROB_SIZE_WIDTH-1:0] id, input logic [XLEN-1:0] v, input logic tk);
      alu_ready = 1'b1;
      alu_id    = id;
      alu_val   = v;
      alu_taken = tk;
      tick();
      alu_ready = 1'b0;
   endtask

   task automatic wb_lsb(input logic [ROB_SIZE_WIDTH-1:0] id, input logic [XLEN-1:0] v);
      lsb_ready = 1'b1;
      lsb_id    = id;
      lsb_val   = v;
      tick();
      lsb_ready = 1'b0;
   endtask

   task automatic wait_drain;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   // Commit monitor: every commit must match the oldest expected {rd, value}.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            if (flush) flush_cnt++;
            if (rob_ready) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL commit_unexpected: got rd=%0d val=0x%0h, expected no commit (t=%0t)",
                           rob_rd, rob_val, $time);
               end else begin
                  mon_e    = exp_q.pop_front();
                  exp_head = exp_head + ROB_SIZE_WIDTH'(1);
                  chk("commit_rd", rob_rd, mon_e[W-1:XLEN]);
                  chk("commit_val", rob_val, mon_e[XLEN-1:0]);
                  chk("commit_head", rob_head_id, exp_head);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[8];
      int j, tmp, f0, f1;
      logic [ROB_SIZE_WIDTH-1:0] t_exp;

      rst = 1'b1; stall = 1'b0;
      dec_ready = 1'b0; dec_inst_type = '0; dec_rd = '0; dec_pc = '0; dec_pred_taken = 1'b0;
      alu_ready = 1'b0; alu_id = '0; alu_val = '0; alu_taken = 1'b0;
      lsb_ready = 1'b0; lsb_id = '0; lsb_val = '0;
      qry_id1 = '0; qry_id2 = '0;
      exp_head = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_full", rob_full, 0);
      chk("rst_tail", rob_tail_id, 0);
      chk("rst_head", rob_head_id, 0);
      chk("rst_ready", rob_ready, 0);
      chk("rst_flush", flush, 0);
      chk("rst_halt", halt, 0);
      chk("rst_rd", rob_rd, 0);
      chk("rst_val", rob_val, 0);
      chk("rst_flush_pc", flush_pc, 0);
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of operation
      for (int i = 0; i < 3; i++) alloc(INST_ADDI, 5'(i + 1), 32'h0, 1'b0, 1'b0, '0, '0);
      chk("midrst_tail_before", rob_tail_id, 3);
      #2 rst = 1'b1;
      #1;
      chk("midrst_full", rob_full, 0);
      chk("midrst_tail", rob_tail_id, 0);
      chk("midrst_head", rob_head_id, 0);
      chk("midrst_ready", rob_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_head = '0;

      // Out-of-order writeback, in-order commit on consecutive cycles
      alloc(INST_ADDI, 5'd5, 32'h10, 1'b0, 1'b1, 5'd5, 32'h11);
      alloc(INST_ADDI, 5'd6, 32'h14, 1'b0, 1'b1, 5'd6, 32'h22);
      alloc(INST_ADDI, 5'd7, 32'h18, 1'b0, 1'b1, 5'd7, 32'h33);
      qry_id1 = 3'd1;
      #1 chk("qry_not_done", qry_rdy1, 0);
      wb_alu(3'd2, 32'h33, 1'b0);
      chk("ooo_no_commit_a", rob_ready, 0);
      wb_alu(3'd0, 32'h11, 1'b0);
      chk("ooo_no_commit_b", rob_ready, 0);
      qry_id1 = 3'd2;
      #1;
      chk("qry_done_rdy", qry_rdy1, 1);
      chk("qry_done_val", qry_val1, 32'h33);
      wb_lsb(3'd1, 32'h22);
      chk("ooo_commit0", rob_ready, 1);
      tick();
      chk("ooo_commit1", rob_ready, 1);
      tick();
      chk("ooo_commit2", rob_ready, 1);
      tick();
      chk("ooo_idle", rob_ready, 0);
      wait_drain();

      // Full and wrap
      do_reset();
      for (int i = 0; i < 8; i++) begin
         chk("fill_not_full", rob_full, 0);
         alloc(INST_ADDI, 5'(i + 1), 32'h40 + 32'(4 * i), 1'b0, 1'b1, 5'(i + 1),
               (i == 4) ? 32'hDEAD : 32'h100 + 32'(i));
         t_exp = 3'(i + 1);
         chk("fill_tail", rob_tail_id, t_exp);
      end
      chk("full_set", rob_full, 1);
      alloc(INST_ADDI, 5'd30, 32'h0, 1'b0, 1'b0, '0, '0);
      chk("full_ignores_alloc_tail", rob_tail_id, 0);
      chk("full_still_full", rob_full, 1);

      // Query bypass on both ports
      qry_id1 = 3'd6; qry_id2 = 3'd5;
      #1;
      chk("qry1_not_done", qry_rdy1, 0);
      chk("qry2_not_done", qry_rdy2, 0);
      alu_ready = 1'b1; alu_id = 3'd4; alu_val = 32'hDEAD; alu_taken = 1'b0;
      lsb_ready = 1'b1; lsb_id = 3'd5; lsb_val = 32'h105;
      qry_id1 = 3'd4;
      #1;
      chk("bypass_alu_rdy", qry_rdy1, 1);
      chk("bypass_alu_val", qry_val1, 32'hDEAD);
      chk("bypass_lsb_rdy", qry_rdy2, 1);
      chk("bypass_lsb_val", qry_val2, 32'h105);
      tick();
      alu_ready = 1'b0; lsb_ready = 1'b0;
      #1;
      chk("stored_rdy", qry_rdy1, 1);
      chk("stored_val", qry_val1, 32'hDEAD);

      // Commit one, allocate one: tail wraps 0 -> 1
      wb_alu(3'd0, 32'h100, 1'b0);
      tick();
      chk("wrap_commit", rob_ready, 1);
      chk("wrap_not_full", rob_full, 0);
      alloc(INST_ADDI, 5'd9, 32'h60, 1'b0, 1'b1, 5'd9, 32'h999);
      chk("wrap_tail", rob_tail_id, 1);
      chk("wrap_full_again", rob_full, 1);
      foreach (order[k]) order[k] = k;
      for (int i = 1; i < 8; i++) begin
         if (i == 4 || i == 5) continue;
         wb_alu(3'(i), 32'h100 + 32'(i), 1'b0);
      end
      wb_alu(3'd0, 32'h999, 1'b0);
      wait_drain();

      // Table-driven stream with shuffled writeback order
      do_reset();
      vecs[0] = '{INST_ADDI, 5'd3,  32'hA0,       1'b0, 1'b0, 1'b0, 5'd3};
      vecs[1] = '{INST_SW,   5'd4,  32'hB1,       1'b0, 1'b0, 1'b1, 5'd0};
      vecs[2] = '{INST_LW,   5'd8,  32'hC2,       1'b0, 1'b0, 1'b1, 5'd8};
      vecs[3] = '{INST_BEQ,  5'd9,  32'h400,      1'b0, 1'b0, 1'b0, 5'd0};
      vecs[4] = '{INST_BNE,  5'd10, 32'h500,      1'b1, 1'b1, 1'b0, 5'd0};
      vecs[5] = '{INST_JAL,  5'd1,  32'h214,      1'b0, 1'b1, 1'b0, 5'd1};
      vecs[6] = '{INST_SB,   5'd2,  32'h66,       1'b0, 1'b0, 1'b1, 5'd0};
      vecs[7] = '{INST_ADD,  5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd31};
      f0 = flush_cnt;
      for (int i = 0; i < 8; i++) begin
         t_exp = 3'(i);
         chk("tbl_tag", rob_tail_id, t_exp);
         alloc(vecs[i].itype, vecs[i].rd, 32'h200 + 32'(4 * i), vecs[i].pred, 1'b1,
               vecs[i].exp_rd, vecs[i].val);
      end
      for (int i = 7; i > 0; i--) begin
         j = $urandom_range(i, 0);
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int k = 0; k < 8; k++) begin
         if (vecs[order[k]].use_lsb) wb_lsb(3'(order[k]), vecs[order[k]].val);
         else wb_alu(3'(order[k]), vecs[order[k]].val, vecs[order[k]].taken);
      end
      wait_drain();
      chk("tbl_no_flush", flush_cnt, f0);

      // Branch misprediction
      do_reset();
      f1 = flush_cnt;
      alloc(INST_ADDI, 5'd3,  32'hFC,  1'b0, 1'b1, 5'd3, 32'h5);
      alloc(INST_BEQ,  5'd12, 32'h100, 1'b0, 1'b1, 5'd0, 32'h80);
      alloc(INST_ADDI, 5'd4,  32'h104, 1'b0, 1'b0, '0, '0);
      alloc(INST_ADDI, 5'd9,  32'h108, 1'b0, 1'b0, '0, '0);
      wb_alu(3'd2, 32'h44, 1'b0);
      wb_alu(3'd0, 32'h5, 1'b0);
      wb_alu(3'd1, 32'h80, 1'b1);
      tick();
      chk("mp_flush", flush, 1);
      chk("mp_flush_pc", flush_pc, 32'h80);
      chk("mp_rob_rd", rob_rd, 0);
      chk("mp_ready", rob_ready, 1);
      alloc(INST_ADDI, 5'd5, 32'h10C, 1'b0, 1'b0, '0, '0);
      chk("mp_flush_done", flush, 0);
      chk("mp_no_commit", rob_ready, 0);
      chk("mp_head", rob_head_id, 2);
      chk("mp_tail_eq_head", rob_tail_id, 2);
      chk("mp_not_full", rob_full, 0);
      qry_id1 = 3'd2;
      #1 chk("mp_entry_cleared", qry_rdy1, 0);
      for (int i = 0; i < 8; i++) begin
         alloc(INST_ADDI, 5'(20 + i), 32'h300, 1'b0, (i == 0), 5'd20, 32'h77);
         chk("mp_count_full", rob_full, (i == 7));
      end
      wb_alu(3'd2, 32'h77, 1'b0);
      wait_drain();
      chk("mp_flush_pulses", flush_cnt - f1, 1);

      // HALT
      do_reset();
      alloc(INST_ADDI, 5'd1, 32'h0, 1'b0, 1'b1, 5'd1, 32'h7);
      alloc(INST_HALT, 5'd0, 32'h4, 1'b0, 1'b1, 5'd0, 32'h0);
      wb_alu(3'd0, 32'h7, 1'b0);
      tick();
      chk("halt_not_yet", halt, 0);
      tick();
      chk("halt_set", halt, 1);
      alloc(INST_ADDI, 5'd2, 32'h8, 1'b0, 1'b0, '0, '0);
      chk("halt_blocks_alloc", rob_tail_id, 2);
      wb_alu(3'd2, 32'h9, 1'b0);
      repeat (3) tick();
      chk("halt_sticky", halt, 1);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement queue between decoder/dispatch and the register file.
- Allocates one entry per dispatched instruction and captures execution results from the ALU and load/store buses.
- Commits the head entry to the register file each cycle, using the rob_ready / rob_rd / rob_val / rob_head_id / rob_tail_id interface.
- Detects branch mispredictions at commit and raises the global flush with a redirect PC.

Parameters:
- ROB_SIZE_WIDTH, 3, log2 of entry count (8 entries).
- XLEN, 32, data and PC width.
- REG_CNT_WIDTH, 5, architectural register index width.

Ports:
- clk  in  1  clock; rising edge active.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  global stall; blocks allocation.
- dec_ready  in  1  decoder presents a valid instruction.
- dec_inst_type  in  INST_TYPE_WIDTH  instruction class.
- dec_rd  in  REG_CNT_WIDTH  destination register.
- dec_pc  in  XLEN  instruction PC.
- dec_pred_taken  in  1  fetch prediction for branches.
- alu_ready  in  1  ALU result valid.
- alu_id  in  ROB_SIZE_WIDTH  ROB tag of the ALU result.
- alu_val  in  XLEN  ALU result (rd value, or branch target).
- alu_taken  in  1  branch resolved taken.
- lsb_ready  in  1  LSB result valid.
- lsb_id  in  ROB_SIZE_WIDTH  ROB tag of the LSB result.
- lsb_val  in  XLEN  load data.
- qry_id1  in  ROB_SIZE_WIDTH  forwarding lookup tag, port 1.
- qry_id2  in  ROB_SIZE_WIDTH  forwarding lookup tag, port 2.
- qry_rdy1  out  1  entry qry_id1 has a result.
- qry_val1  out  XLEN  that result.
- qry_rdy2  out  1  entry qry_id2 has a result.
- qry_val2  out  XLEN  that result.
- rob_full  out  1  no free entry.
- rob_ready  out  1  commit pulse (registered).
- rob_rd  out  REG_CNT_WIDTH  committed destination.
- rob_val  out  XLEN  committed value.
- rob_head_id  out  ROB_SIZE_WIDTH  head pointer after commit; the committed tag is rob_head_id-1.
- rob_tail_id  out  ROB_SIZE_WIDTH  tag that the next allocation receives.
- flush  out  1  misprediction flush pulse (registered).
- flush_pc  out  XLEN  redirect PC.
- halt  out  1  HALT committed; sticky.

Behaviour:
- Per-entry state: busy, done, type, rd, pc, pred_taken, value, taken.
- Pointers head and tail are ROB_SIZE_WIDTH bits wide and wrap modulo 2^ROB_SIZE_WIDTH.
- An entry count of ROB_SIZE_WIDTH+1 bits disambiguates full from empty.
- Reset (async):
  - head=tail=count=0, all busy=0.
  - rob_ready=0, flush=0, halt=0.
  - rob_rd=0, rob_val=0, flush_pc=0.
- Allocate:
  - Condition: dec_ready && !stall && !rob_full && !flush.
  - Writes entry[tail] with busy=1, done=0.
  - Store-type and branch-type instructions are stored with rd forced to 0.
  - HALT is allocated with done=1.
  - tail increments by 1.
- rob_full = (count == 2^ROB_SIZE_WIDTH).
  - The decoder must not present a new instruction while rob_full=1.
  - rob_full is combinational from the registered count.
- Writeback:
  - Each valid bus sets done=1 and writes value at its tag.
  - The ALU bus also writes taken.
  - Both buses may be valid in the same cycle; they carry distinct tags.
  - Writeback to a non-busy tag is ignored.
- Query: combinational.
  - qry_rdy = busy && done at the tag.
  - A same-cycle ALU/LSB writeback to the queried tag is bypassed, giving rdy=1 with the bus value.
- Commit, when entry[head] is busy && done and flush is not being issued:
  - Next edge: rob_ready=1, rob_rd=entry.rd, rob_val=entry.value.
  - head increments, count decrements, busy clears.
  - At most one commit per cycle.
  - Otherwise rob_ready=0 on the next edge.
- Simultaneous allocate and commit: count is unchanged and both pointers advance.
- Branch commit:
  - If taken != pred_taken: flush=1 for one cycle.
  - flush_pc = taken ? value : pc+4.
  - The branch commits with rob_rd=0.
- Flush cycle (flush=1 registered):
  - On the following edge all entries are cleared and count=0.
  - head is retained; tail is set to head, so tags restart from head.
  - Allocation is blocked during this cycle.
  - rob_ready is 0 during the cycle after flush.
- HALT commit: halt=1 (sticky until reset); no further commits or allocations.
- JAL/JALR: value carries the link value (rd write).
  - JALR misprediction redirect is handled elsewhere.
  - No flush from JAL/JALR here.
- Latency:
  - Allocate to earliest commit: 1 cycle after done.
  - Writeback to rob_ready: 1 cycle when the entry is at head.

Decomposition:
- Shared package (global_params.v): XLEN, REG_CNT_WIDTH, ROB_SIZE_WIDTH, INST_TYPE_WIDTH, DEPENDENCY_WIDTH, and the instruction type codes (HALT, BEQ..BGEU, SB/SH/SW, JAL, JALR).
- One sub-module, rob_query_port: combinational tag lookup with writeback bypass, instantiated twice.

Test Plan:
- Reset mid-operation:
  - Stimulus: allocate 3 entries, assert rst.
  - Required response: rob_full=0, rob_tail_id=0, rob_head_id=0, rob_ready=0 immediately after reset.
- Out-of-order writeback:
  - Stimulus: allocate tags 0,1,2 (rd=5,6,7); write back tag 2 (val 0x33), then 0 (0x11), then 1 (0x22).
  - Required response: commits, in order, (rd=5, 0x11, head=1), then (6, 0x22, head=2), then (7, 0x33, head=3) on consecutive cycles.
- Full and wrap:
  - Stimulus: allocate 8 entries.
  - Required response: rob_full=1 and the 9th dec_ready is ignored.
  - Stimulus: commit 1, then allocate 1.
  - Required response: tail wraps to 1 and rob_tail_id sequence ...7,0,1.
- Query bypass:
  - Stimulus: ALU writes tag 4 with 0xDEAD in the same cycle that qry_id1=4.
  - Required response: qry_rdy1=1, qry_val1=0xDEAD.
  - Stimulus: query a non-done tag.
  - Required response: qry_rdy=0.
- Misprediction:
  - Stimulus: BEQ at pc 0x100, pred_taken=0, resolves taken with target 0x80; younger entries pending.
  - Required response: flush=1, flush_pc=0x80, rob_rd=0; the next cycle has count=0 and tail=head.
- HALT:
  - Stimulus: allocate ADDI (rd=1) then HALT; write back the ADDI.
  - Required response: ADDI commits, then halt=1 stays high and further dec_ready is ignored.
